// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-cycle W-bit adder.
// It adds one SLICE_W-bit ripple-carry slice per cycle, from the least
// significant slice up, so one operation takes N = W/SLICE_W cycles in RUN.
//
// Ports:
//   clk, rst_n         single clock; asynchronous active-low reset
//   in_valid, in_ready request handshake (in_ready is high only in IDLE)
//   a, b, c_in         addends and carry-in, latched when a request is accepted
//   out_valid, out_ready result handshake (out_valid is high only in DONE)
//   sum, c_out, ovf    a + b + c_in mod 2^W, carry out, and signed overflow
//   busy               high while in RUN or DONE
module add_seq_ctrl #(
    parameter int unsigned W       = 64,
    parameter int unsigned SLICE_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned N     = W / SLICE_W;
    localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    if ((W % SLICE_W) != 0) begin : g_bad_slice_w
        $error("add_seq_ctrl: W must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic                carry_q;
    logic [W-1:0]        a_q, b_q;
    logic [W-1:0]        sum_q;
    logic                c_out_q, ovf_q;

    int unsigned         slice_base;
    logic [SLICE_W-1:0]  a_slice, b_slice;
    logic [SLICE_W:0]    slice_res;
    logic                carry_into_msb;

    // Slice datapath
    always_comb begin
        slice_base = 32'(k_q) * SLICE_W;
        a_slice    = a_q[slice_base +: SLICE_W];
        b_slice    = b_q[slice_base +: SLICE_W];
        slice_res  = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry_q};
        // Only meaningful on the last slice, where slice bit SLICE_W-1 is bit W-1.
        carry_into_msb = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ slice_res[SLICE_W-1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid)   state_d = StRun;
            StRun:  if (k_q == KLast) state_d = StDone;
            StDone: if (out_ready)  state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Outputs are decoded from state so reset takes effect without a clock.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StRun) || (state_q == StDone);
        sum       = sum_q;
        c_out     = c_out_q;
        ovf       = ovf_q;
    end

    // Operand latch, slice accumulation and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        k_q     <= '0;
                    end
                end
                StRun: begin
                    sum_q[slice_base +: SLICE_W] <= slice_res[SLICE_W-1:0];
                    carry_q                      <= slice_res[SLICE_W];
                    if (k_q == KLast) begin
                        k_q     <= '0;
                        c_out_q <= slice_res[SLICE_W];
                        ovf_q   <= carry_into_msb ^ slice_res[SLICE_W];
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 64, operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE_W, default 16, width of the internal ripple-carry slice processed per cycle; W SHALL be an integer multiple of SLICE_W; N = W/SLICE_W.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  request carries valid operands.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port a  input  W  first addend.
REQ-008 The block SHALL have port b  input  W  second addend.
REQ-009 The block SHALL have port c_in  input  1  carry-in.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port sum  output  W  a + b + c_in, modulo 2^W.
REQ-013 The block SHALL have port c_out  output  1  carry out of bit W-1.
REQ-014 The block SHALL have port ovf  output  1  signed overflow = carry into bit W-1 XOR c_out.
REQ-015 The block SHALL have port busy  output  1  high in RUN and DONE states.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 In IDLE, on in_valid && in_ready at a rising edge, the block SHALL latch a, b, c_in, set slice index k = 0, set the carry register to c_in, and enter RUN.
REQ-018 In RUN, each cycle the block SHALL add bits [k*SLICE_W +: SLICE_W] of latched a and b plus the carry register, write the result into the same bits of the sum register, load the slice carry-out into the carry register, and increment k.
REQ-019 On the cycle processing slice k = N-1 the block SHALL capture the carry into bit W-1 and the final carry, and enter DONE.
REQ-020 Latency SHALL be exactly N cycles from the accepting edge to out_valid high (4 cycles with defaults); SLICE_W = W SHALL yield 1 cycle.
REQ-021 In DONE, sum, c_out, ovf SHALL remain stable until out_valid && out_ready at a rising edge, then the block SHALL return to IDLE.
REQ-022 in_valid and operand changes outside IDLE SHALL be ignored; latched operands SHALL not change during RUN.
REQ-023 Back-to-back requests with out_ready held high SHALL complete one operation every N+2 cycles (IDLE accept, N RUN, 1 DONE).
REQ-024 Wrap-around: carries SHALL propagate across all slice boundaries; the sum SHALL be the low W bits of a + b + c_in with the extra bit on c_out.
REQ-025 sum, c_out, ovf SHALL be meaningful only while out_valid = 1; between operations they SHALL hold the last completed result until the next acceptance.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately force state IDLE, k = 0, carry register 0, sum = 0, c_out = 0, ovf = 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result produced; the first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-028 a = 0, b = 0, c_in = 0 -> out_valid 4 cycles after accept; sum = 0, c_out = 0, ovf = 0.
REQ-029 a = FFFF_FFFF_FFFF_FFFF, b = 0, c_in = 1 -> sum = 0, c_out = 1, ovf = 0 (carry ripples through all 4 slices).
REQ-030 a = 7FFF_FFFF_FFFF_FFFF, b = 1, c_in = 0 -> sum = 8000_0000_0000_0000, c_out = 0, ovf = 1.
REQ-031 out_ready held low 10 cycles in DONE with in_valid = 1 and new operands -> out_valid, sum, c_out stay stable, in_ready = 0, no new request accepted.
REQ-032 rst_n pulsed low while k = 2 -> all outputs zero, in_ready = 1 asynchronously; next request a = 1, b = 2, c_in = 0 -> sum = 3.
REQ-033 10,000 random a, b, c_in with out_ready = 1 -> every result matches golden a + b + c_in (sum, c_out, ovf); accepts spaced exactly N+2 = 6 cycles.
